// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_stage
//  Description : Instruction-fetch stage between pre-IF and decode. Holds one
//                PC entry, waits for its instruction SRAM response, buffers
//                the instruction while decode is stalled, and discards the
//                responses of requests cancelled by a flush.
//  Revision    : 1.0  initial release
// ============================================================================
module if_stage #(
    parameter int PS_TO_FS_BUS_WD = 41,
    parameter int FS_TO_DS_BUS_WD = 73,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       ps_to_fs_valid,
    input  logic [PS_TO_FS_BUS_WD-1:0] ps_to_fs_bus,
    output logic                       fs_allowin,
    input  logic                       ds_allowin,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    input  logic                       data_ok,
    input  logic [31:0]                inst_sram_rdata,
    input  logic                       flush,
    output logic                       fs_wait_resp
);

    localparam int DROP_W    = $clog2(MAX_OUTSTANDING + 1);
    localparam int PS_EX_BIT = 32;

    logic                       fs_valid_q,  fs_valid_d;
    logic                       buf_valid_q, buf_valid_d;
    logic [31:0]                inst_buf_q,  inst_buf_d;
    logic [PS_TO_FS_BUS_WD-1:0] bus_q,       bus_d;
    logic [DROP_W-1:0]          drop_cnt_q,  drop_cnt_d;

    logic              fs_ex;
    logic              live_resp;
    logic              fs_ready_go;
    logic              fs_accept;
    logic              fs_leave;
    logic              buf_load;
    logic [31:0]       fs_inst;
    logic              drop_inc_cur;
    logic              drop_inc_new;
    logic              drop_dec;
    logic [DROP_W:0]   drop_sum;

    // Handshake, bypass and status signals derived from the held entry
    always_comb begin
        fs_ex          = bus_q[PS_EX_BIT];
        live_resp      = data_ok && (drop_cnt_q == '0);
        fs_ready_go    = fs_ex || buf_valid_q || (live_resp && fs_valid_q);
        fs_allowin     = !fs_valid_q || (fs_ready_go && ds_allowin);
        fs_to_ds_valid = fs_valid_q && fs_ready_go && !flush;
        fs_wait_resp   = fs_valid_q && !fs_ex && !buf_valid_q;
        fs_accept      = ps_to_fs_valid && fs_allowin && !flush;
        fs_leave       = fs_to_ds_valid && ds_allowin;
        buf_load       = live_resp && fs_valid_q && !fs_ex && !buf_valid_q && !ds_allowin;
        // Exception entries never issued a request, so they carry no instruction
        if (fs_ex) begin
            fs_inst = 32'h0;
        end else if (buf_valid_q) begin
            fs_inst = inst_buf_q;
        end else begin
            fs_inst = inst_sram_rdata;
        end
        fs_to_ds_bus = {bus_q[PS_TO_FS_BUS_WD-1:PS_EX_BIT+1], fs_ex, fs_inst, bus_q[31:0]};
    end

    // Count of cancelled requests whose responses must still be swallowed
    always_comb begin
        drop_inc_cur = flush && fs_wait_resp && !live_resp;
        drop_inc_new = flush && ps_to_fs_valid && fs_allowin && !ps_to_fs_bus[PS_EX_BIT];
        drop_dec     = data_ok && (drop_cnt_q != '0);
        drop_sum     = {1'b0, drop_cnt_q}
                     + {{DROP_W{1'b0}}, drop_inc_cur}
                     + {{DROP_W{1'b0}}, drop_inc_new}
                     - {{DROP_W{1'b0}}, drop_dec};
        if (drop_sum > (DROP_W+1)'(MAX_OUTSTANDING)) begin
            drop_cnt_d = DROP_W'(MAX_OUTSTANDING);
        end else begin
            drop_cnt_d = drop_sum[DROP_W-1:0];
        end
    end

    // Entry and instruction-buffer next state; flush has priority over all
    always_comb begin
        fs_valid_d  = fs_valid_q;
        buf_valid_d = buf_valid_q;
        inst_buf_d  = inst_buf_q;
        bus_d       = bus_q;
        if (flush) begin
            fs_valid_d  = 1'b0;
            buf_valid_d = 1'b0;
        end else if (fs_accept) begin
            bus_d       = ps_to_fs_bus;
            fs_valid_d  = 1'b1;
            buf_valid_d = 1'b0;
        end else if (fs_leave) begin
            fs_valid_d  = 1'b0;
            buf_valid_d = 1'b0;
        end else if (buf_load) begin
            inst_buf_d  = inst_sram_rdata;
            buf_valid_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            fs_valid_q  <= 1'b0;
            buf_valid_q <= 1'b0;
            inst_buf_q  <= 32'h0;
            bus_q       <= '0;
            drop_cnt_q  <= '0;
        end else begin
            fs_valid_q  <= fs_valid_d;
            buf_valid_q <= buf_valid_d;
            inst_buf_q  <= inst_buf_d;
            bus_q       <= bus_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // A response with no live entry and nothing to discard has no owner
    a_no_orphan_resp: assert property (@(posedge clk) disable iff (!resetn)
        !(data_ok && !flush && !fs_valid_q && (drop_cnt_q == '0)));

    // More cancelled requests than the pipeline can have in flight
    a_no_drop_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !(drop_sum > (DROP_W+1)'(MAX_OUTSTANDING)));

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_stage
//  Description : Directed self-checking bench for the instruction-fetch stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_stage;

    logic        clk;
    logic        resetn;
    logic        ps_to_fs_valid;
    logic [40:0] ps_to_fs_bus;
    logic        fs_allowin;
    logic        ds_allowin;
    logic        fs_to_ds_valid;
    logic [72:0] fs_to_ds_bus;
    logic        data_ok;
    logic [31:0] inst_sram_rdata;
    logic        flush;
    logic        fs_wait_resp;

    int errors = 0;
    int checks = 0;

    if_stage #(
        .PS_TO_FS_BUS_WD (41),
        .FS_TO_DS_BUS_WD (73),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .ps_to_fs_valid  (ps_to_fs_valid),
        .ps_to_fs_bus    (ps_to_fs_bus),
        .fs_allowin      (fs_allowin),
        .ds_allowin      (ds_allowin),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_to_ds_bus    (fs_to_ds_bus),
        .data_ok         (data_ok),
        .inst_sram_rdata (inst_sram_rdata),
        .flush           (flush),
        .fs_wait_resp    (fs_wait_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {s0_ex, s0_refill_ex, ecode, ps_ex, pc}
    function automatic logic [40:0] ps_bus(input logic [5:0] ecode, input logic ex, input logic [31:0] pc);
        return {1'b0, 1'b0, ecode, ex, pc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ps_to_fs_valid  = 1'b0;
        ps_to_fs_bus    = '0;
        ds_allowin      = 1'b1;
        data_ok         = 1'b0;
        inst_sram_rdata = 32'h0;
        flush           = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle();
        tick();
        tick();
        checks++; if (fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", fs_to_ds_valid); end
        checks++; if (fs_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin: got %b want 1", fs_allowin); end
        checks++; if (fs_wait_resp !== 1'b0) begin errors++; $display("FAIL reset_wait: got %b want 0", fs_wait_resp); end
        checks++; if (fs_to_ds_bus !== 73'h0) begin errors++; $display("FAIL reset_bus: got %h want 0", fs_to_ds_bus); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        ps_to_fs_valid = 1'b1;
        ps_to_fs_bus   = ps_bus(6'h0, 1'b0, 32'h1c000000);
        #1;
        checks++; if (fs_allowin !== 1'b1) begin errors++; $display("FAIL basic_accept: got %b want 1", fs_allowin); end
        tick();
        idle();
        data_ok = 1'b1; inst_sram_rdata = 32'h02800c0c;
        #1;
        checks++; if (fs_to_ds_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", fs_to_ds_valid); end
        checks++; if (fs_to_ds_bus[63:32] !== 32'h02800c0c) begin errors++; $display("FAIL basic_inst: got %h want 02800c0c", fs_to_ds_bus[63:32]); end
        checks++; if (fs_to_ds_bus[31:0] !== 32'h1c000000) begin errors++; $display("FAIL basic_pc: got %h want 1c000000", fs_to_ds_bus[31:0]); end
        checks++; if (fs_to_ds_bus[64] !== 1'b0) begin errors++; $display("FAIL basic_ex: got %b want 0", fs_to_ds_bus[64]); end
        tick();
        idle();
        #1;
        checks++; if (fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL basic_gone: got %b want 0", fs_to_ds_valid); end
    endtask

    task automatic test_stall();
        int handshakes = 0;
        ps_to_fs_valid = 1'b1;
        ps_to_fs_bus   = ps_bus(6'h0, 1'b0, 32'h1c000004);
        tick();
        idle();
        ds_allowin = 1'b0; data_ok = 1'b1; inst_sram_rdata = 32'h11112222;
        #1;
        checks++; if (fs_to_ds_valid !== 1'b1 || fs_allowin !== 1'b0) begin errors++; $display("FAIL stall_resp: got valid=%b allowin=%b want 1/0", fs_to_ds_valid, fs_allowin); end
        tick();
        for (int i = 0; i < 2; i++) begin
            data_ok = 1'b0; inst_sram_rdata = 32'h33334444;
            #1;
            checks++; if (fs_to_ds_bus[63:32] !== 32'h11112222 || fs_to_ds_valid !== 1'b1) begin errors++; $display("FAIL stall_hold: got inst=%h valid=%b want 11112222/1", fs_to_ds_bus[63:32], fs_to_ds_valid); end
            checks++; if (fs_allowin !== 1'b0 || fs_wait_resp !== 1'b0) begin errors++; $display("FAIL stall_flags: got allowin=%b wait=%b want 0/0", fs_allowin, fs_wait_resp); end
            tick();
        end
        ds_allowin = 1'b1;
        #1;
        checks++; if (fs_allowin !== 1'b1 || fs_to_ds_bus[63:32] !== 32'h11112222 || fs_to_ds_bus[31:0] !== 32'h1c000004) begin errors++; $display("FAIL stall_release: got allowin=%b inst=%h pc=%h want 1/11112222/1c000004", fs_allowin, fs_to_ds_bus[63:32], fs_to_ds_bus[31:0]); end
        for (int i = 0; i < 3; i++) begin
            #1;
            if (fs_to_ds_valid === 1'b1 && ds_allowin === 1'b1) handshakes++;
            tick();
        end
        checks++; if (handshakes != 1) begin errors++; $display("FAIL stall_once: got %0d handshakes want 1", handshakes); end
    endtask

    task automatic test_flush_wait();
        ps_to_fs_valid = 1'b1;
        ps_to_fs_bus   = ps_bus(6'h0, 1'b0, 32'h1c000008);
        tick();
        idle();
        flush = 1'b1;
        #1;
        checks++; if (fs_to_ds_valid !== 1'b0 || fs_wait_resp !== 1'b1) begin errors++; $display("FAIL fw_flush: got valid=%b wait=%b want 0/1", fs_to_ds_valid, fs_wait_resp); end
        tick();
        idle();
        ps_to_fs_valid = 1'b1;
        ps_to_fs_bus   = ps_bus(6'h0, 1'b0, 32'h1c000100);
        #1;
        checks++; if (fs_allowin !== 1'b1) begin errors++; $display("FAIL fw_accept: got %b want 1", fs_allowin); end
        tick();
        idle();
        data_ok = 1'b1; inst_sram_rdata = 32'hdeadbeef;
        #1;
        checks++; if (fs_to_ds_valid !== 1'b0 || fs_wait_resp !== 1'b1) begin errors++; $display("FAIL fw_stale: got valid=%b wait=%b want 0/1", fs_to_ds_valid, fs_wait_resp); end
        tick();
        inst_sram_rdata = 32'h0badf00d;
        #1;
        checks++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus[63:32] !== 32'h0badf00d || fs_to_ds_bus[31:0] !== 32'h1c000100) begin errors++; $display("FAIL fw_deliver: got valid=%b inst=%h pc=%h want 1/0badf00d/1c000100", fs_to_ds_valid, fs_to_ds_bus[63:32], fs_to_ds_bus[31:0]); end
        tick();
        idle();
        #1;
    endtask

    task automatic test_flush_double();
        ps_to_fs_valid = 1'b1;
        ps_to_fs_bus   = ps_bus(6'h0, 1'b0, 32'h1c000010);
        tick();
        idle();
        flush = 1'b1;
        tick();
        flush = 1'b1; ps_to_fs_valid = 1'b1;
        ps_to_fs_bus = ps_bus(6'h0, 1'b0, 32'h1c000014);
        #1;
        checks++; if (fs_allowin !== 1'b1 || fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL fd_flush2: got allowin=%b valid=%b want 1/0", fs_allowin, fs_to_ds_valid); end
        tick();
        idle();
        ps_to_fs_valid = 1'b1;
        ps_to_fs_bus   = ps_bus(6'h0, 1'b0, 32'h1c000020);
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            data_ok = 1'b1; inst_sram_rdata = 32'hbad00000 + 32'(i);
            #1;
            checks++; if (fs_to_ds_valid !== 1'b0 || fs_wait_resp !== 1'b1) begin errors++; $display("FAIL fd_drop%0d: got valid=%b wait=%b want 0/1", i, fs_to_ds_valid, fs_wait_resp); end
            tick();
        end
        data_ok = 1'b1; inst_sram_rdata = 32'h12345678;
        #1;
        checks++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus[63:32] !== 32'h12345678 || fs_to_ds_bus[31:0] !== 32'h1c000020) begin errors++; $display("FAIL fd_deliver: got valid=%b inst=%h pc=%h want 1/12345678/1c000020", fs_to_ds_valid, fs_to_ds_bus[63:32], fs_to_ds_bus[31:0]); end
        tick();
        idle();
        #1;
    endtask

    task automatic test_ps_ex();
        ps_to_fs_valid = 1'b1;
        ps_to_fs_bus   = ps_bus(6'h08, 1'b1, 32'h1c000002);
        tick();
        idle();
        inst_sram_rdata = 32'hffffffff;
        #1;
        checks++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus[64] !== 1'b1 || fs_wait_resp !== 1'b0) begin errors++; $display("FAIL ex_valid: got valid=%b ex=%b wait=%b want 1/1/0", fs_to_ds_valid, fs_to_ds_bus[64], fs_wait_resp); end
        checks++; if (fs_to_ds_bus[63:32] !== 32'h0 || fs_to_ds_bus[70:65] !== 6'h08 || fs_to_ds_bus[31:0] !== 32'h1c000002) begin errors++; $display("FAIL ex_fields: got inst=%h ecode=%h pc=%h want 0/08/1c000002", fs_to_ds_bus[63:32], fs_to_ds_bus[70:65], fs_to_ds_bus[31:0]); end
        tick();
        idle();
        ps_to_fs_valid = 1'b1;
        ps_to_fs_bus   = ps_bus(6'h08, 1'b1, 32'h1c000006);
        tick();
        idle();
        ds_allowin = 1'b0; flush = 1'b1;
        #1;
        checks++; if (fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL ex_flush: got %b want 0", fs_to_ds_valid); end
        tick();
        idle();
        ps_to_fs_valid = 1'b1;
        ps_to_fs_bus   = ps_bus(6'h0, 1'b0, 32'h1c000030);
        tick();
        idle();
        data_ok = 1'b1; inst_sram_rdata = 32'hcafe0001;
        #1;
        checks++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus[63:32] !== 32'hcafe0001) begin errors++; $display("FAIL ex_nodrop: got valid=%b inst=%h want 1/cafe0001", fs_to_ds_valid, fs_to_ds_bus[63:32]); end
        tick();
        idle();
        #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        ps_to_fs_valid = 1'b1;
        ps_to_fs_bus   = ps_bus(6'h0, 1'b0, 32'h1c000200);
        tick();
        for (int k = 1; k <= 8; k++) begin
            ps_to_fs_valid  = (k < 8);
            ps_to_fs_bus    = ps_bus(6'h0, 1'b0, 32'h1c000200 + 32'(k * 4));
            data_ok         = 1'b1;
            inst_sram_rdata = 32'ha0000000 + 32'(k - 1);
            exp_pc          = 32'h1c000200 + 32'((k - 1) * 4);
            #1;
            checks++; if (fs_to_ds_valid !== 1'b1 || fs_allowin !== 1'b1 || fs_to_ds_bus[31:0] !== exp_pc || fs_to_ds_bus[63:32] !== 32'ha0000000 + 32'(k - 1)) begin errors++; $display("FAIL b2b_%0d: got valid=%b allowin=%b pc=%h inst=%h want 1/1/%h/%h", k, fs_to_ds_valid, fs_allowin, fs_to_ds_bus[31:0], fs_to_ds_bus[63:32], exp_pc, 32'ha0000000 + 32'(k - 1)); end
            tick();
        end
        idle();
        #1;
        checks++; if (fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b want 0", fs_to_ds_valid); end
    endtask

    task automatic test_mid_reset();
        ps_to_fs_valid = 1'b1;
        ps_to_fs_bus   = ps_bus(6'h0, 1'b0, 32'h1c000300);
        tick();
        idle();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        #1;
        checks++; if (fs_wait_resp !== 1'b0 || fs_allowin !== 1'b1 || fs_to_ds_valid !== 1'b0) begin errors++; $display("FAIL midreset: got wait=%b allowin=%b valid=%b want 0/1/0", fs_wait_resp, fs_allowin, fs_to_ds_valid); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_flush_wait();
        test_flush_double();
        test_ps_ex();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
